// File: rtl/mem_bus_access.sv
// Data-memory access sequencer: turns MEM-stage load/store strobes into a req/ack
// bus transaction, stalling the pipeline until it completes or times out.
module mem_bus_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic [31:0] loaddata,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       loaddata_reg, loaddata_next;
    logic              load_valid_reg, load_valid_next;
    logic              addr_err_reg, addr_err_next;
    logic              bus_err_reg, bus_err_next;

    logic access;
    logic aligned;

    assign access  = memread | memwrite;
    assign aligned = (memaddr[1:0] == 2'b00);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        req_next        = req_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        loaddata_next   = loaddata_reg;
        load_valid_next = 1'b0;
        addr_err_next   = 1'b0;
        bus_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    if (aligned) begin
                        state_next = REQ;
                        req_next   = 1'b1;
                        we_next    = memwrite;  // a write wins when both strobes are high
                        addr_next  = memaddr;
                        wdata_next = memwritedata;
                        cnt_next   = '0;
                    end else begin
                        addr_err_next = 1'b1;
                    end
                end
            end
            REQ: begin
                // ack takes priority over a timeout expiring in the same cycle
                if (bus_ack) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    if (!we_reg) begin
                        loaddata_next   = bus_rdata;
                        load_valid_next = 1'b1;
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next    = DONE;
                    req_next      = 1'b0;
                    loaddata_next = '0;
                    bus_err_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            loaddata_reg   <= '0;
            load_valid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            req_reg        <= req_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            loaddata_reg   <= loaddata_next;
            load_valid_reg <= load_valid_next;
            addr_err_reg   <= addr_err_next;
            bus_err_reg    <= bus_err_next;
        end
    end

    // stall is the only combinational output; it must read 0 while reset is held
    assign stall = !rst && (((state_reg == IDLE) && access && aligned) || (state_reg == REQ));

    assign bus_req    = req_reg;
    assign bus_we     = we_reg;
    assign bus_addr   = addr_reg;
    assign bus_wdata  = wdata_reg;
    assign loaddata   = loaddata_reg;
    assign load_valid = load_valid_reg;
    assign addr_err   = addr_err_reg;
    assign bus_err    = bus_err_reg;

endmodule

// File: doc/mem_bus_access.md
Name: mem_bus_access

Overview:
- Data-memory access sequencer directly downstream of the MEM address/write-data stage.
- Takes the word address, store data and read/write strobes produced there and runs a req/ack transaction on the data-memory bus.
- Stalls the pipeline while a transaction is outstanding and presents registered load data to the MEM/WB boundary.
- Handles word accesses only; misaligned accesses and bus timeouts are flagged.

Parameters:
- TIMEOUT, 16: max cycles in REQ without bus_ack before abort (2..255).
- CNT_W, 8: width of timeout counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- memaddr  input  32  word address from MEM stage.
- memwritedata  input  32  store data from MEM stage.
- memread  input  1  load request for current MEM instruction.
- memwrite  input  1  store request for current MEM instruction.
- bus_rdata  input  32  read data from data memory, valid with bus_ack.
- bus_ack  input  1  single-cycle completion from data memory.
- bus_req  output  1  transaction request, held until ack or timeout.
- bus_we  output  1  1 = write, 0 = read; valid while bus_req.
- bus_addr  output  32  latched address, valid while bus_req.
- bus_wdata  output  32  latched store data, valid while bus_req.
- stall  output  1  freezes PC/IF/ID/EX/MEM registers while high.
- loaddata  output  32  registered load result for WB.
- load_valid  output  1  one-cycle pulse: loaddata updated by a completed read.
- addr_err  output  1  one-cycle pulse: misaligned access rejected.
- bus_err  output  1  one-cycle pulse: transaction aborted by timeout.

Behaviour:
- Reset (async, immediate): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, loaddata=0, load_valid=0, addr_err=0, bus_err=0, counter=0. stall=0 while rst high.
- Access detected in IDLE when memread|memwrite. If both are high, write wins (bus_we=1).
- States:
  - IDLE: access with memaddr[1:0]==0 → latch memaddr/memwritedata/we, go to REQ. Access with memaddr[1:0]!=0 → no bus activity, addr_err=1 next cycle, stay IDLE. No access → stay.
  - REQ: bus_req=1, outputs stable. bus_ack → if read, loaddata<=bus_rdata; go to DONE; bus_req=0 next cycle. Counter increments each REQ cycle without ack. Counter reaching TIMEOUT-1 without ack → drop bus_req, loaddata<=0, go to DONE with bus_err pulse.
  - DONE: exactly one cycle. load_valid=1 only for a read completed by ack. Next state is always IDLE; the request in the current cycle is not re-sampled.
- stall is combinational: (IDLE & aligned access) | REQ. It is 0 in DONE, so the pipeline advances at the end of DONE and a fresh instruction is in MEM when IDLE is re-entered.
- Minimum latency, ack in first REQ cycle:
  - cycle 0: IDLE detect, stall=1.
  - cycle 1: REQ + ack.
  - cycle 2: DONE, loaddata valid, stall=0.
  - Back-to-back accesses therefore cost 3 cycles each.
- Misaligned access never asserts stall. The instruction advances with loaddata unchanged and load_valid=0.
- bus_ack outside REQ is ignored. Ack arriving in the same cycle as timeout expiry counts as a successful ack (ack has priority).
- Counter clears on entry to REQ. CNT_W must hold TIMEOUT.
- Reset asserted mid-transaction drops bus_req and returns to IDLE at once. There is no completion pulse.
- All outputs except stall are registered.

Test Plan:
- Aligned load: memread=1, memaddr=0x0000_0010, ack at 2nd REQ cycle with bus_rdata=0xDEAD_BEEF → bus_req high 2 cycles with bus_we=0, bus_addr=0x10; stall high 3 cycles; loaddata=0xDEAD_BEEF with load_valid pulse in DONE.
- Aligned store: memwrite=1, memaddr=0x24, memwritedata=0x1234_5678, ack in 1st REQ cycle → bus_we=1, bus_wdata=0x1234_5678; load_valid stays 0; loaddata unchanged.
- Misaligned: memread=1, memaddr=0x0000_0013 → bus_req never asserts, stall=0, addr_err pulse one cycle later.
- Timeout (TIMEOUT=4): store to 0x40, no ack → bus_req high exactly 4 cycles, then bus_err pulse; late ack afterwards ignored; stall released.
- Async reset during REQ: assert rst between clock edges → bus_req=0 and stall=0 immediately. After release, a new load to 0x8 completes normally.
- Both strobes high plus back-to-back: memread=memwrite=1 to 0x0, then a load to 0x4 → first access is a write; second access starts in the cycle after DONE; total 6 cycles with immediate acks.
